// File: rtl/serial_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_arbiter
// Description : Two requesters share one 2-bit full-adder slice through a
//               round-robin arbiter. An accepted WIDTH-bit addition runs
//               serially, least-significant slice first, with a registered
//               carry. The (WIDTH+1)-bit result is returned on a single
//               valid/ready response channel, tagged with the requester id.
//
// Ports       : clock, reset           - system clock, sync active-high reset
//               req0_valid/ready/a/b   - requester 0 operation channel
//               req1_valid/ready/a/b   - requester 1 operation channel
//               resp_valid/ready       - response handshake
//               resp_sum               - a+b, bit WIDTH is the final carry
//               resp_id                - requester index of the result
//               busy                   - high while running or holding a result
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH:0]   resp_sum,
    output logic             resp_id,
    output logic             busy
);

    localparam int SLICES = WIDTH / 2;
    localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CNT_W-1:0] C_LAST_SLICE = CNT_W'(SLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ptr_q, ptr_d;       // 0: req0 favoured, 1: req1 favoured
    logic [WIDTH-1:0] acc_q, acc_d;       // working sum, separate from resp_sum
    logic [WIDTH:0]   resp_sum_q, resp_sum_d;
    logic             resp_id_q, resp_id_d;

    logic             grant_valid;
    logic             grant_id;
    logic [2:0]       slice_sum;

    // Grant to the sole valid requester, or to the favoured one on contention.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (req0_valid && (!req1_valid || !ptr_q)) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    // Readys are forced low while reset is asserted so nothing is accepted.
    assign req0_ready = (state_q == S_IDLE) && !reset && grant_valid && !grant_id;
    assign req1_ready = (state_q == S_IDLE) && !reset && grant_valid &&  grant_id;

    // Shared 2-bit full-adder slice selected by the slice counter.
    assign slice_sum = {1'b0, a_q[{cnt_q, 1'b0} +: 2]}
                     + {1'b0, b_q[{cnt_q, 1'b0} +: 2]}
                     + {2'b00, carry_q};

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        acc_d      = acc_q;
        resp_sum_d = resp_sum_q;
        resp_id_d  = resp_id_q;

        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    a_d     = grant_id ? req1_a : req0_a;
                    b_d     = grant_id ? req1_b : req0_b;
                    id_d    = grant_id;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    ptr_d   = ~grant_id;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d[{cnt_q, 1'b0} +: 2] = slice_sum[1:0];
                carry_d = slice_sum[2];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == C_LAST_SLICE) begin
                    // Result becomes visible only once complete.
                    resp_sum_d = {slice_sum[2], acc_d};
                    resp_id_d  = id_q;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            ptr_q      <= 1'b0;
            acc_q      <= '0;
            resp_sum_q <= '0;
            resp_id_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            acc_q      <= acc_d;
            resp_sum_q <= resp_sum_d;
            resp_id_q  <= resp_id_d;
        end
    end

    assign resp_valid = (state_q == S_DONE);
    assign resp_sum   = resp_sum_q;
    assign resp_id    = resp_id_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_arbiter
// Description : Directed, table-driven bench for serial_adder_arbiter with
//               hand-written sequences for contention, backpressure and
//               mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_arbiter;

    localparam int WIDTH  = 8;
    localparam int SLICES = WIDTH / 2;

    logic             clock;
    logic             reset;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             resp_valid, resp_ready;
    logic [WIDTH:0]   resp_sum;
    logic             resp_id;
    logic             busy;

    int checks = 0;
    int errors = 0;

    serial_adder_arbiter #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   sum;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Starts right after a falling edge; returns #1 after a falling edge.
    task automatic do_op(input logic id, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH:0] exp);
        resp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        chk("accept_ready", id ? req1_ready : req0_ready, 1);
        chk("other_ready",  id ? req0_ready : req1_ready, 0);
        @(negedge clock);
        // Operands change after accept and must be ignored.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req0_b = 8'h5A; req1_a = ~a; req1_b = 8'hA5;
        for (int i = 0; i < SLICES; i++) begin
            #1;
            chk("run_busy", busy, 1);
            chk("run_no_resp", resp_valid, 0);
            @(negedge clock);
        end
        #1;
        chk("resp_valid", resp_valid, 1);
        chk("resp_sum", resp_sum, exp);
        chk("resp_id", resp_id, id);
        chk("done_busy", busy, 1);
        @(negedge clock);
        #1;
        chk("post_resp_valid", resp_valid, 0);
        chk("post_busy", busy, 0);
    endtask

    // Waits (bounded) for resp_valid, checks it, completes handshake.
    task automatic wait_resp(input string nm, input logic [WIDTH:0] exp_sum, input logic exp_id);
        bit found = 0;
        resp_ready = 1'b1;
        for (int i = 0; i < 12 && !found; i++) begin
            #1;
            if (resp_valid) found = 1;
            else @(negedge clock);
        end
        chk({nm, "_seen"}, found, 1);
        if (found) begin
            chk({nm, "_sum"}, resp_sum, exp_sum);
            chk({nm, "_id"}, resp_id, exp_id);
        end
        @(negedge clock);
    endtask

    initial begin
        int    nresp;
        bit    exp_id;
        bit    stale;

        vecs[0] = '{1'b0, 8'h03, 8'h01, 9'h004};
        vecs[1] = '{1'b1, 8'hFF, 8'h01, 9'h100};
        vecs[2] = '{1'b0, 8'h55, 8'hAB, 9'h100};
        vecs[3] = '{1'b1, 8'hAA, 8'h55, 9'h0FF};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 9'h000};
        vecs[5] = '{1'b1, 8'h80, 8'h80, 9'h100};

        reset = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
        req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44;

        // Reset state: readys low during reset even with valids high.
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_sum", resp_sum, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_busy", busy, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // Single-requester vectors.
        for (int v = 0; v < 6; v++) begin
            do_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sum);
        end

        // Contention from reset: alternate 0,1,0,... one op per SLICES+2.
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20;
        req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55;
        nresp  = 0;
        exp_id = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (req0_ready && req1_ready) chk("both_ready", 1, 0);
            if (resp_valid && resp_ready) begin
                chk("cont_id", resp_id, exp_id);
                chk("cont_sum", resp_sum, exp_id ? 9'h0FF : 9'h030);
                exp_id = ~exp_id;
                nresp++;
            end
            @(negedge clock);
        end
        chk("cont_count", nresp, 5);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure in DONE.
        @(negedge clock);
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
        #1;
        chk("bp_accept", req0_ready, 1);
        @(negedge clock);
        req0_valid = 1'b0;
        begin
            bit found = 0;
            for (int i = 0; i < 12 && !found; i++) begin
                #1;
                if (resp_valid) found = 1;
                else @(negedge clock);
            end
            chk("bp_resp_seen", found, 1);
        end
        req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", resp_valid, 1);
            chk("bp_sum", resp_sum, 9'h046);
            chk("bp_id", resp_id, 0);
            chk("bp_r0", req0_ready, 0);
            chk("bp_r1", req1_ready, 0);
            @(negedge clock);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_hs_valid", resp_valid, 1);
        chk("bp_hs_r1", req1_ready, 0);
        @(negedge clock);
        #1;
        chk("bp_idle_valid", resp_valid, 0);
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_accept", req1_ready, 1);
        @(negedge clock);
        req1_valid = 1'b0;
        #1;
        chk("bp_next_busy", busy, 1);
        wait_resp("bp_next", 9'h003, 1'b1);

        // Reset during the second RUN cycle.
        reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
        @(negedge clock);                 // first RUN cycle
        req0_valid = 1'b0;
        @(negedge clock);                 // second RUN cycle
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mr_resp_valid", resp_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_sum", resp_sum, 0);
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (resp_valid) stale = 1;
            @(negedge clock);
        end
        chk("mr_no_stale", stale, 0);
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01;
        req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55;
        #1;
        chk("mr_ptr_r0", req0_ready, 1);
        chk("mr_ptr_r1", req1_ready, 0);
        @(negedge clock);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_resp("mr_after", 9'h002, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
